// File: rtl/handshake_sender_pkg.sv
// rtl/handshake_sender_pkg.sv - shared types and helpers for the 4-phase handshake initiator
//
// Contents:
//   hs_state_t      2-bit FSM state encoding {IDLE, WAIT_ACK_HIGH, WAIT_ACK_LOW, ABORT}
//   hs_cnt_width()  width of the per-state timeout counter for a given TIMEOUT_CYCLES
package handshake_sender_pkg;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    WAIT_ACK_HIGH = 2'd1,
    WAIT_ACK_LOW  = 2'd2,
    ABORT         = 2'd3
  } hs_state_t;

  // Counter must hold 0..TIMEOUT_CYCLES. A disabled timeout (0) would give a
  // zero-width vector, so fall back to a single bit that is never compared.
  function automatic int hs_cnt_width(input int timeout_cycles);
    if (timeout_cycles > 0) begin
      return $clog2(timeout_cycles + 1);
    end
    return 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - single-bit multi-flop synchronizer for asynchronous inputs
//
// Parameters:
//   SYNC_STAGES  number of flops in the chain (values below 2 are raised to 2)
// Ports:
//   clk      in   destination clock
//   reset_n  in   asynchronous active-low reset, clears the chain to 0
//   d        in   asynchronous input bit
//   q        out  d delayed through SYNC_STAGES flops, safe to use in the clk domain
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  // A single flop gives no metastability protection, so never build fewer than two.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/handshake_sender.sv
// rtl/handshake_sender.sv - initiator side of a 4-phase req/ack handshake with optional timeout
//
// Parameters:
//   DATA_WIDTH      width of tx_data / req_data
//   SYNC_STAGES     synchronizer depth on ack (minimum 2)
//   TIMEOUT_CYCLES  cycles allowed in each wait state; 0 disables the timeout
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   tx_valid       in   local request to send tx_data
//   tx_data        in   word to send, captured on acceptance
//   tx_ready       out  a word can be accepted this cycle
//   req            out  registered handshake request to the responder
//   req_data       out  captured word, stable while req or synchronized ack is high
//   ack            in   responder acknowledge, asynchronous to clk
//   busy           out  a handshake is in progress (state != IDLE)
//   done_pulse     out  one cycle high when a handshake completes
//   timeout_pulse  out  one cycle high when a wait state runs out of time
module handshake_sender
  import handshake_sender_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] req_data,
  input  logic                  ack,
  output logic                  busy,
  output logic                  done_pulse,
  output logic                  timeout_pulse
);

  localparam int              CNT_W      = hs_cnt_width(TIMEOUT_CYCLES);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  hs_state_t             state, state_nxt;
  logic                  req_nxt;
  logic [DATA_WIDTH-1:0] req_data_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  done_nxt;
  logic                  timeout_nxt;
  logic                  ack_s;
  logic                  timeout_hit;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (ack),
    .q      (ack_s)
  );

  // A responder still holding ack from an interrupted handshake blocks new
  // requests until it lets go; this keeps the phases from getting out of step.
  assign tx_ready    = (state == IDLE) && !ack_s;
  assign busy        = (state != IDLE);
  assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      req           <= 1'b0;
      req_data      <= '0;
      cnt           <= '0;
      done_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      req           <= req_nxt;
      req_data      <= req_data_nxt;
      cnt           <= cnt_nxt;
      done_pulse    <= done_nxt;
      timeout_pulse <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    req_nxt      = req;
    req_data_nxt = req_data;
    done_nxt     = 1'b0;
    timeout_nxt  = 1'b0;
    // Saturate instead of wrapping so a disabled or very long timeout can
    // never alias back onto CNT_LAST.
    cnt_nxt      = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (tx_valid && tx_ready) begin
          req_data_nxt = tx_data;
          req_nxt      = 1'b1;
          state_nxt    = WAIT_ACK_HIGH;
        end
      end

      WAIT_ACK_HIGH: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          state_nxt = WAIT_ACK_LOW;
          cnt_nxt   = '0;
        end else if (timeout_hit) begin
          // Withdraw req and wait in ABORT for a late ack to drain.
          req_nxt     = 1'b0;
          timeout_nxt = 1'b1;
          state_nxt   = ABORT;
          cnt_nxt     = '0;
        end
      end

      WAIT_ACK_LOW: begin
        if (!ack_s) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (timeout_hit) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
          cnt_nxt     = '0;
        end
      end

      ABORT: begin
        if (!ack_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (timeout_hit) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
          cnt_nxt     = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
